branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Sits directly upstream of the PC update stage in Fetch.
- Looks up the current InstrAddr in a direct-mapped branch target buffer (BTB) that holds 2-bit saturating counters.
- Drives Predict (the predicted target) and PCSource (take the prediction) in the same cycle, so the PC update stage can select the next fetch address.
- Is trained by resolved-branch updates coming back from the execute stage.

Parameters:
- ENTRIES, 16, number of BTB entries; must be a power of 2.
- IDX_W, 4, log2(ENTRIES); index width.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- InstrAddr  in  32  current fetch address from the PC update stage.
- Predict  out  32  predicted branch target; 0 when PCSource=0.
- PCSource  out  1  1 = take Predict as the next fetch address.
- UpdEn  in  1  resolved-branch update valid (from EX).
- UpdPC  in  32  address of the resolved branch.
- UpdTaken  in  1  actual branch outcome.
- UpdTarget  in  32  actual branch target.
- PredHit  out  1  valid tag match at InstrAddr, independent of the counter value.

Behaviour:
- Storage per entry:
  - valid (1 bit)
  - tag (32-IDX_W-2 bits)
  - target (32 bits)
  - ctr (2 bits)
- Address split:
  - index = addr[IDX_W+1:2]
  - tag = addr[31:IDX_W+2]
  - addr[1:0] is ignored (word-aligned instructions).
- Lookup is purely combinational from registered state, with zero-cycle latency.
  - PredHit = valid[idx] & (tag[idx]==InstrAddr tag).
  - PCSource = PredHit & ctr[idx][1].
  - Predict = PCSource ? target[idx] : 32'b0.
- Counter encoding:
  - 0 = strong not-taken (SNT)
  - 1 = weak not-taken (WNT)
  - 2 = weak taken (WT)
  - 3 = strong taken (ST)
  - Counters saturate at 0 and 3; no wrap.
- Update, on a rising edge when UpdEn=1, indexed by UpdPC:
  - Hit and UpdTaken=1: ctr = min(ctr+1, 3); target <= UpdTarget.
  - Hit and UpdTaken=0: ctr = max(ctr-1, 0); target unchanged; entry stays valid.
  - Miss and UpdTaken=1: allocate the entry. valid<=1, tag<=UpdPC tag, target<=UpdTarget, ctr<=2 (WT). Any aliased entry is overwritten unconditionally.
  - Miss and UpdTaken=0: no state change; there is no allocation for not-taken branches.
- UpdEn=0: state holds.
- Same-cycle lookup and update to the same index:
  - Lookup returns the pre-update contents; there is no bypass.
  - The new state is visible on the next cycle.
- Reset, asserted at any time including mid-update:
  - Asynchronously clears all valid bits to 0 and all ctr fields to 0.
  - Tag and target contents are don't-care but must also be cleared, to keep simulation X-free.
  - While Rst=1: PCSource=0, PredHit=0, Predict=0.
  - An update presented during reset is discarded.
- The block has no stall input. The PC update stage ignores PCSource during stall or flush, and EX issues UpdEn once per resolved branch.

Decomposition:
- Shared package (fetch_pkg):
  - Counter state constants: CTR_SNT=2'd0, CTR_WNT=2'd1, CTR_WT=2'd2, CTR_ST=2'd3.
  - CTR_ALLOC=CTR_WT.
  - Address index/tag slicing widths derived from IDX_W.
- One natural sub-module: sat_counter2. It is combinational next-state logic with inputs (ctr, taken) and output (ctr_next), with saturation. It is instantiated once on the update path.
- The table arrays and lookup logic live in branch_predictor itself.

Test Plan:
1. Reset: assert Rst mid-run with a previously trained entry at 0x40, then release. Lookup of InstrAddr=0x40 must give PCSource=0, PredHit=0, Predict=0.
2. Allocate and hit: UpdEn=1, UpdPC=0x100, UpdTaken=1, UpdTarget=0x200. On the next cycle, InstrAddr=0x100 must give PredHit=1, PCSource=1, Predict=0x200 (ctr=WT).
3. Saturation and hysteresis, starting from test 2:
   - Two further taken updates give ctr=ST (no wrap past 3).
   - One not-taken update gives WT, so PCSource remains 1.
   - A second not-taken update gives WNT, so PCSource=0 and PredHit=1.
   - Two more not-taken updates give SNT, which stays at 0.
4. No allocate on not-taken miss: UpdPC=0x300, UpdTaken=0. InstrAddr=0x300 must give PredHit=0.
5. Aliasing (ENTRIES=16):
   - Train 0x100 as taken to target 0x200.
   - Then apply a taken update at 0x140 (same index, different tag) with target 0x500.
   - InstrAddr=0x100 must give PredHit=0. InstrAddr=0x140 must give Predict=0x500.
6. Same-cycle hazard: set InstrAddr=0x600 and UpdPC=0x600 taken with target 0x700 in the same cycle.
   - That cycle: PCSource=0.
   - Next cycle: PCSource=1, Predict=0x700.
   - Also check that a lookup with InstrAddr[1:0]=2'b11 matches the same entry.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared Fetch-stage definitions: 2-bit branch counter encodings and the
// address slicing helpers used by the branch target buffer.
package fetch_pkg;

  localparam logic [1:0] CTR_SNT   = 2'd0;
  localparam logic [1:0] CTR_WNT   = 2'd1;
  localparam logic [1:0] CTR_WT    = 2'd2;
  localparam logic [1:0] CTR_ST    = 2'd3;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  localparam int ADDR_W  = 32;
  localparam int ALIGN_W = 2;

  // Tag covers every address bit above the index and the word-offset bits.
  function automatic int tagWidth(input int idxW);
    return ADDR_W - idxW - ALIGN_W;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module sat_counter2
  import fetch_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup for Fetch,
// trained by resolved-branch updates from EX.
module branch_predictor
  import fetch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] InstrAddr,
  output logic [31:0] Predict,
  output logic        PCSource,
  input  logic        UpdEn,
  input  logic [31:0] UpdPC,
  input  logic        UpdTaken,
  input  logic [31:0] UpdTarget,
  output logic        PredHit
);

  localparam int TAG_W = tagWidth(IDX_W);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_lookIdx;
  logic [TAG_W-1:0] w_lookTag;
  logic [IDX_W-1:0] w_updIdx;
  logic [TAG_W-1:0] w_updTag;
  logic             w_updHit;
  logic [1:0]       w_ctrNext;
  logic             w_unused;

  assign w_lookIdx = InstrAddr[IDX_W+1:ALIGN_W];
  assign w_lookTag = InstrAddr[ADDR_W-1:IDX_W+ALIGN_W];
  assign w_updIdx  = UpdPC[IDX_W+1:ALIGN_W];
  assign w_updTag  = UpdPC[ADDR_W-1:IDX_W+ALIGN_W];
  assign w_unused  = ^{InstrAddr[1:0], UpdPC[1:0]};

  // Reads come straight from registered state, so a same-cycle update is not bypassed.
  assign PredHit  = ~Rst & r_valid[w_lookIdx] & (r_tag[w_lookIdx] == w_lookTag);
  assign PCSource = PredHit & r_ctr[w_lookIdx][1];
  assign Predict  = PCSource ? r_target[w_lookIdx] : 32'b0;

  assign w_updHit = r_valid[w_updIdx] & (r_tag[w_updIdx] == w_updTag);

  sat_counter2 u_satCounter (
    .ctr      (r_ctr[w_updIdx]),
    .taken    (UpdTaken),
    .ctr_next (w_ctrNext)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_SNT;
      end
    end else if (UpdEn) begin
      if (w_updHit) begin
        r_ctr[w_updIdx] <= w_ctrNext;
        if (UpdTaken) r_target[w_updIdx] <= UpdTarget;
      end else if (UpdTaken) begin
        // Taken miss replaces whatever alias occupies the slot.
        r_valid[w_updIdx]  <= 1'b1;
        r_tag[w_updIdx]    <= w_updTag;
        r_target[w_updIdx] <= UpdTarget;
        r_ctr[w_updIdx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: stimulus pushes expected
// lookup results, a negedge monitor pops and compares them.
module tb_branch_predictor;

  logic        Clk;
  logic        Rst;
  logic [31:0] InstrAddr;
  logic [31:0] Predict;
  logic        PCSource;
  logic        UpdEn;
  logic [31:0] UpdPC;
  logic        UpdTaken;
  logic [31:0] UpdTarget;
  logic        PredHit;

  typedef struct {
    string       name;
    logic        hit;
    logic        src;
    logic [31:0] pred;
  } expect_t;

  expect_t expQ[$];
  logic    chkValid;
  string   chkName;
  int      total;
  int      bad;

  branch_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .InstrAddr (InstrAddr),
    .Predict   (Predict),
    .PCSource  (PCSource),
    .UpdEn     (UpdEn),
    .UpdPC     (UpdPC),
    .UpdTaken  (UpdTaken),
    .UpdTarget (UpdTarget),
    .PredHit   (PredHit)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One cycle of stimulus: lookup address plus optional update, with the
  // lookup result expected in that same cycle.
  task automatic applyStimulus(input string name, input logic rst,
                               input logic [31:0] addr, input logic en,
                               input logic [31:0] pc, input logic tk,
                               input logic [31:0] tgt, input logic expHit,
                               input logic expSrc, input logic [31:0] expPred);
    expect_t e;
    @(posedge Clk);
    #1;
    Rst       = rst;
    InstrAddr = addr;
    UpdEn     = en;
    UpdPC     = pc;
    UpdTaken  = tk;
    UpdTarget = tgt;
    e.name = name;
    e.hit  = expHit;
    e.src  = expSrc;
    e.pred = expPred;
    expQ.push_back(e);
    chkName  = name;
    chkValid = 1'b1;
  endtask

  task automatic checkOutput(input expect_t e);
    total++;
    if (PredHit !== e.hit) begin
      bad++;
      $display("[TB] FAIL %s PredHit: got %b expected %b", e.name, PredHit, e.hit);
    end
    total++;
    if (PCSource !== e.src) begin
      bad++;
      $display("[TB] FAIL %s PCSource: got %b expected %b", e.name, PCSource, e.src);
    end
    total++;
    if (Predict !== e.pred) begin
      bad++;
      $display("[TB] FAIL %s Predict: got 0x%08h expected 0x%08h", e.name, Predict, e.pred);
    end
  endtask

  always @(negedge Clk) begin
    if (chkValid) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL %s scoreboard: got empty queue expected an entry", chkName);
      end else begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  initial begin
    int waitCycles;
    total     = 0;
    bad       = 0;
    chkValid  = 1'b0;
    chkName   = "";
    Rst       = 1'b1;
    InstrAddr = '0;
    UpdEn     = 1'b0;
    UpdPC     = '0;
    UpdTaken  = 1'b0;
    UpdTarget = '0;
    repeat (2) @(posedge Clk);

    //            name          rst  addr         en   pc           tk   tgt          hit  src  pred
    applyStimulus("rstInit",    0, 32'h0000_0040, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0);
    applyStimulus("trainA",     0, 32'h0000_0040, 1, 32'h0000_0040, 1, 32'h0000_0044, 0, 0, 32'h0);
    applyStimulus("trainedA",   0, 32'h0000_0040, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0000_0044);
    applyStimulus("inReset",    1, 32'h0000_0040, 1, 32'h0000_0040, 1, 32'h0000_0048, 0, 0, 32'h0);
    applyStimulus("postReset",  0, 32'h0000_0040, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0);

    applyStimulus("allocMiss",  0, 32'h0000_0100, 1, 32'h0000_0100, 1, 32'h0000_0200, 0, 0, 32'h0);
    applyStimulus("hitWT",      0, 32'h0000_0100, 1, 32'h0000_0100, 1, 32'h0000_0200, 1, 1, 32'h0000_0200);
    applyStimulus("hitST",      0, 32'h0000_0100, 1, 32'h0000_0100, 1, 32'h0000_0200, 1, 1, 32'h0000_0200);
    applyStimulus("satST",      0, 32'h0000_0100, 1, 32'h0000_0100, 0, 32'h0,        1, 1, 32'h0000_0200);
    applyStimulus("downWT",     0, 32'h0000_0100, 1, 32'h0000_0100, 0, 32'h0,        1, 1, 32'h0000_0200);
    applyStimulus("downWNT",    0, 32'h0000_0100, 1, 32'h0000_0100, 0, 32'h0,        1, 0, 32'h0);
    applyStimulus("downSNT",    0, 32'h0000_0100, 1, 32'h0000_0100, 0, 32'h0,        1, 0, 32'h0);
    applyStimulus("satSNT",     0, 32'h0000_0100, 1, 32'h0000_0100, 1, 32'h0000_0200, 1, 0, 32'h0);
    applyStimulus("upWNT",      0, 32'h0000_0100, 1, 32'h0000_0100, 1, 32'h0000_0204, 1, 0, 32'h0);
    applyStimulus("newTarget",  0, 32'h0000_0100, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0000_0204);

    applyStimulus("ntMissUpd",  0, 32'h0000_0300, 1, 32'h0000_0300, 0, 32'h0000_0999, 0, 0, 32'h0);
    applyStimulus("ntMissKeep", 0, 32'h0000_0100, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0000_0204);
    applyStimulus("ntMissNone", 0, 32'h0000_0300, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0);

    applyStimulus("aliasUpd",   0, 32'h0000_0104, 1, 32'h0000_0140, 1, 32'h0000_0500, 0, 0, 32'h0);
    applyStimulus("aliasOld",   0, 32'h0000_0100, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0);
    applyStimulus("aliasNew",   0, 32'h0000_0140, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0000_0500);

    applyStimulus("hazardSame", 0, 32'h0000_0600, 1, 32'h0000_0600, 1, 32'h0000_0700, 0, 0, 32'h0);
    applyStimulus("hazardNext", 0, 32'h0000_0600, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0000_0700);
    applyStimulus("lowBits",    0, 32'h0000_0603, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0000_0700);
    applyStimulus("tagDiffer",  0, 32'h0000_0642, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0);
    applyStimulus("updDisable", 0, 32'h0000_0600, 0, 32'h0000_0600, 0, 32'h0,        1, 1, 32'h0000_0700);
    applyStimulus("holdCheck",  0, 32'h0000_0600, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0000_0700);

    @(posedge Clk);
    #1;
    chkValid = 1'b0;
    UpdEn    = 1'b0;

    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 10) begin
      @(posedge Clk);
      waitCycles++;
    end
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
